cmos_fbuf_sched: RTL and testbench
==================================

Name: cmos_fbuf_sched

Overview:
- Frame-buffer write scheduler and triple-buffer bank manager between the CMOS capture path and the DDR3 write port.
- Counts incoming camera pixel words and issues burst write requests (address plus length) to the DDR3 write master.
- Rotates among three frame banks so the LCD reader always scans the most recent complete frame and never a bank being written.
- Frame geometry comes from the camera-size configuration outputs (cmos_h_pixel, cmos_v_pixel, ddr3_addr_max).

Parameters:
BURST_LEN, 64, words per full DDR3 write burst (1..255)
BANK_STRIDE, 28'h0200000, word-address distance between frame banks

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
cmos_h_pixel  in  13  active pixels per line
cmos_v_pixel  in  13  active lines per frame
ddr3_addr_max  in  28  max words per frame (clamp)
wr_frame_start  in  1  1-cycle pulse: camera frame begins
wr_pix_vld  in  1  one pixel word entered write FIFO this cycle
rd_frame_start  in  1  1-cycle pulse: LCD read frame begins
wr_req  out  1  burst write request
wr_ack  in  1  1-cycle burst accept, only while wr_req=1
wr_addr  out  28  burst start word address
wr_len  out  8  burst length in words (1..BURST_LEN)
wr_bank  out  2  bank being written
rd_bank  out  2  bank the reader must use
rd_base  out  28  rd_bank*BANK_STRIDE
frame_err  out  1  1-cycle pulse: short frame aborted
frame_cnt  out  16  completed frames, wraps

Behaviour:
- Reset values: wr_req=0, wr_addr=0, wr_len=0, wr_bank=0, rd_bank=2, rd_base=2*BANK_STRIDE, frame_err=0, frame_cnt=0, latest=2, latest_vld=0, state IDLE, all counters 0.
- Outputs are registered. Every request decision appears on wr_req the cycle after its condition holds.
- Target latch: on wr_frame_start, target = min(cmos_h_pixel*cmos_v_pixel, ddr3_addr_max), held in a 28-bit register (full-width product). Config changes mid-frame are ignored. target=0 completes the frame immediately with no request.
- States:
  - IDLE: wr_pix_vld ignored. wr_frame_start latches target, clears pix_cnt, pend and offset, then enters ACTIVE.
  - ACTIVE: each wr_pix_vld with pix_cnt<target increments pix_cnt and pend. Pixels with pix_cnt==target are dropped.
  - Request rule (ACTIVE): when wr_req=0 and either pend>=BURST_LEN, or pix_cnt==target with pend>0, assert wr_req with:
    - wr_len = min(pend, BURST_LEN)
    - wr_addr = wr_bank*BANK_STRIDE + offset
  - Handshake: wr_req, wr_addr and wr_len are held stable until wr_ack. On wr_ack: wr_req drops, offset += wr_len, and pend -= wr_len. A wr_pix_vld in the same cycle still increments pend. A new request can issue no earlier than the cycle after ack.
  - Completion: pix_cnt==target, pend==0 and wr_req==0, then go to DONE.
  - DONE (1 cycle):
    - latest <= wr_bank, latest_vld <= 1, frame_cnt++.
    - wr_bank <= 3 - new latest - rd_bank_next, i.e. the third bank.
    - Then go to IDLE.
  - Early start: wr_frame_start in ACTIVE pulses frame_err and gives no bank rotation.
    - If wr_req=0: clear counters, latch new target, stay in ACTIVE in the same bank.
    - If wr_req=1: go to ABORT. ABORT holds wr_req until wr_ack, ignores pixels and frame starts, then goes to IDLE.
  - wr_frame_start in DONE or ABORT is ignored.
- Reader bank selection:
  - On rd_frame_start with latest_vld=1, rd_bank <= latest and rd_base is updated the same cycle. With latest_vld=0, rd_bank is unchanged.
  - If rd_frame_start coincides with DONE, the reader takes the just-completed bank (old wr_bank). wr_bank then becomes the remaining third bank.
  - rd_bank never equals wr_bank after reset.
- Widths: pix_cnt, offset and pend are 28 bits. The write FIFO depth guarantee is upstream; no overflow detection here.
- Reset mid-operation: rst has priority over everything. Any outstanding wr_req drops immediately, and the DDR3 master must also be reset.

Test Plan:
- Target 480x272 = 130560 words, BURST_LEN=64, ack 3 cycles after each req → 2040 bursts of len 64, wr_addr 0,64,…,130496; DONE → frame_cnt=1, latest=0, wr_bank=1.
- 5x5 frame (25 words), ddr3_addr_max=1000 → bursts are deferred until frame end: single req len 25 at addr 0 after 25th pixel; a 26th pixel is dropped.
- 1280x800 with ddr3_addr_max=1024000 clamp honoured; 40x40 with ddr3_addr_max=1000 → frame ends at 1000 words, final burst len 1000-15*64=40.
- Early wr_frame_start after 100 pixels with wr_req high → frame_err pulse, ABORT until ack, then IDLE; frame_cnt unchanged, wr_bank unchanged.
- Three frames written, rd_frame_start coincident with second DONE → rd_bank=1, wr_bank=2 (not 0); rd_bank never equals wr_bank throughout.
- rst asserted mid-burst with wr_req=1 → next cycle all outputs at reset values, rd_bank=2, rd_base=2*BANK_STRIDE.

Source files
------------

// File: rtl/cmos_fbuf_sched.sv
// Frame-buffer write scheduler: turns the camera pixel stream into DDR3 burst
// write requests and rotates three frame banks between the writer and the LCD reader.
module cmos_fbuf_sched #(
  parameter int          BURST_LEN   = 64,
  parameter logic [27:0] BANK_STRIDE = 28'h0200000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [12:0] cmos_h_pixel,
  input  logic [12:0] cmos_v_pixel,
  input  logic [27:0] ddr3_addr_max,
  input  logic        wr_frame_start,
  input  logic        wr_pix_vld,
  input  logic        rd_frame_start,
  output logic        wr_req,
  input  logic        wr_ack,
  output logic [27:0] wr_addr,
  output logic [7:0]  wr_len,
  output logic [1:0]  wr_bank,
  output logic [1:0]  rd_bank,
  output logic [27:0] rd_base,
  output logic        frame_err,
  output logic [15:0] frame_cnt
);

  localparam logic [1:0]  S_IDLE   = 2'd0;
  localparam logic [1:0]  S_ACTIVE = 2'd1;
  localparam logic [1:0]  S_DONE   = 2'd2;
  localparam logic [1:0]  S_ABORT  = 2'd3;
  localparam logic [27:0] BURST_W  = 28'(BURST_LEN);
  localparam logic [7:0]  BURST_B  = 8'(BURST_LEN);

  function automatic logic [27:0] bank_base(input logic [1:0] bank);
    case (bank)
      2'd0:    bank_base = 28'd0;
      2'd1:    bank_base = BANK_STRIDE;
      2'd2:    bank_base = BANK_STRIDE + BANK_STRIDE;
      default: bank_base = 28'd0;
    endcase
  endfunction

  logic [1:0]  r_state;
  logic [1:0]  r_latest;
  logic        r_latest_vld;
  logic [27:0] r_target;
  logic [27:0] r_pix_cnt;
  logic [27:0] r_pend;
  logic [27:0] r_offset;

  logic [25:0] w_prod;
  logic [27:0] w_new_target;
  logic        w_pix_acc;
  logic        w_ack;
  logic        w_req_cond;
  logic        w_complete;
  logic [7:0]  w_req_len;
  logic [27:0] w_pend_next;
  logic        w_rd_take;
  logic [1:0]  w_rd_next;
  logic [1:0]  w_excl;
  logic [1:0]  w_wr_third;

  // Frame target and burst request decisions from the registered counters.
  always_comb begin
    w_prod       = 26'(cmos_h_pixel) * 26'(cmos_v_pixel);
    w_new_target = ({2'b00, w_prod} < ddr3_addr_max) ? {2'b00, w_prod} : ddr3_addr_max;
    w_pix_acc    = wr_pix_vld && (r_pix_cnt < r_target);
    w_ack        = wr_req && wr_ack;
    w_req_cond   = !wr_req && ((r_pend >= BURST_W) ||
                               ((r_pix_cnt == r_target) && (r_pend != 28'd0)));
    w_complete   = (r_pix_cnt == r_target) && (r_pend == 28'd0) && !wr_req;
    w_pend_next  = r_pend;
    if (w_pix_acc) begin
      w_pend_next = w_pend_next + 28'd1;
    end else begin
      w_pend_next = w_pend_next;
    end
    if (w_ack) begin
      w_pend_next = w_pend_next - {20'd0, wr_len};
    end else begin
      w_pend_next = w_pend_next;
    end
    if (r_pend < BURST_W) begin
      w_req_len = r_pend[7:0];
    end else begin
      w_req_len = BURST_B;
    end
  end

  // Reader bank choice and the free bank left for the writer after a frame completes.
  always_comb begin
    w_rd_take = rd_frame_start && (r_latest_vld || (r_state == S_DONE));
    if (!w_rd_take) begin
      w_rd_next = rd_bank;
    end else if (r_state == S_DONE) begin
      w_rd_next = wr_bank;
    end else begin
      w_rd_next = r_latest;
    end
    // When the reader grabs the bank just finished, the previous complete frame is kept.
    if (w_rd_next == wr_bank) begin
      w_excl = r_latest;
    end else begin
      w_excl = w_rd_next;
    end
    w_wr_third = 2'd3 - wr_bank - w_excl;
  end

  // Scheduler state, counters and all registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_latest     <= 2'd2;
      r_latest_vld <= 1'b0;
      r_target     <= 28'd0;
      r_pix_cnt    <= 28'd0;
      r_pend       <= 28'd0;
      r_offset     <= 28'd0;
      wr_req       <= 1'b0;
      wr_addr      <= 28'd0;
      wr_len       <= 8'd0;
      wr_bank      <= 2'd0;
      rd_bank      <= 2'd2;
      rd_base      <= bank_base(2'd2);
      frame_err    <= 1'b0;
      frame_cnt    <= 16'd0;
    end else begin
      frame_err <= 1'b0;
      rd_bank   <= w_rd_next;
      rd_base   <= bank_base(w_rd_next);
      case (r_state)
        S_IDLE: begin
          if (wr_frame_start) begin
            r_target  <= w_new_target;
            r_pix_cnt <= 28'd0;
            r_pend    <= 28'd0;
            r_offset  <= 28'd0;
            r_state   <= S_ACTIVE;
          end
        end
        S_ACTIVE: begin
          if (wr_frame_start) begin
            frame_err <= 1'b1;
            if (wr_req) begin
              // An ack landing with the restart already closes the burst.
              if (wr_ack) begin
                wr_req  <= 1'b0;
                r_state <= S_IDLE;
              end else begin
                r_state <= S_ABORT;
              end
            end else begin
              r_target  <= w_new_target;
              r_pix_cnt <= 28'd0;
              r_pend    <= 28'd0;
              r_offset  <= 28'd0;
            end
          end else begin
            r_pix_cnt <= r_pix_cnt + {27'd0, w_pix_acc};
            r_pend    <= w_pend_next;
            if (w_ack) begin
              wr_req   <= 1'b0;
              r_offset <= r_offset + {20'd0, wr_len};
            end else if (w_req_cond) begin
              wr_req  <= 1'b1;
              wr_len  <= w_req_len;
              wr_addr <= bank_base(wr_bank) + r_offset;
            end else if (w_complete) begin
              r_state <= S_DONE;
            end
          end
        end
        S_DONE: begin
          r_latest     <= wr_bank;
          r_latest_vld <= 1'b1;
          frame_cnt    <= frame_cnt + 16'd1;
          wr_bank      <= w_wr_third;
          r_state      <= S_IDLE;
        end
        S_ABORT: begin
          if (w_ack) begin
            wr_req  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cmos_fbuf_sched.sv
// Directed bench for cmos_fbuf_sched: a frame table plus hand sequences for
// restart, abort, reset and reader/writer bank collisions.
module tb_cmos_fbuf_sched;

  localparam logic [27:0] STRIDE = 28'h0200000;

  logic        clk = 1'b0;
  logic        rst;
  logic [12:0] cmos_h_pixel, cmos_v_pixel;
  logic [27:0] ddr3_addr_max;
  logic        wr_frame_start, wr_pix_vld, rd_frame_start;
  logic        wr_req, wr_ack;
  logic [27:0] wr_addr, rd_base;
  logic [7:0]  wr_len;
  logic [1:0]  wr_bank, rd_bank;
  logic        frame_err;
  logic [15:0] frame_cnt;

  logic        ack_auto, ack_man, resp_en;
  logic [27:0] exp_base, exp_target;
  int          nb, sum_len, last_len;
  int          total = 0;
  int          bad = 0;

  assign wr_ack = ack_auto | ack_man;

  always #5 clk = ~clk;

  cmos_fbuf_sched #(.BURST_LEN(64), .BANK_STRIDE(28'h0200000)) dut (
    .clk(clk), .rst(rst),
    .cmos_h_pixel(cmos_h_pixel), .cmos_v_pixel(cmos_v_pixel), .ddr3_addr_max(ddr3_addr_max),
    .wr_frame_start(wr_frame_start), .wr_pix_vld(wr_pix_vld), .rd_frame_start(rd_frame_start),
    .wr_req(wr_req), .wr_ack(wr_ack), .wr_addr(wr_addr), .wr_len(wr_len),
    .wr_bank(wr_bank), .rd_bank(rd_bank), .rd_base(rd_base),
    .frame_err(frame_err), .frame_cnt(frame_cnt)
  );

  typedef struct {
    logic [12:0] h;
    logic [12:0] v;
    logic [27:0] amax;
    int          npix;
    bit          rd_pulse;
    logic [27:0] tgt;
    logic [1:0]  bank;
    int          nbursts;
    int          last;
    logic [1:0]  wr_after;
    logic [1:0]  rd_after;
    int          fc;
  } frame_t;

  frame_t tbl[5];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic logic [27:0] base_of(input logic [1:0] b);
    return 28'(b) * STRIDE;
  endfunction

  // Reader and writer must never share a bank outside reset.
  always @(negedge clk) begin
    if (rst === 1'b0) chk("bank_clash", {31'd0, rd_bank == wr_bank}, 32'd0);
  end

  // Auto responder: acks each request 3 cycles later and checks address/length.
  initial begin
    logic [27:0] rem;
    logic [7:0]  elen;
    ack_auto = 1'b0;
    forever begin
      @(negedge clk);
      if (resp_en && wr_req) begin
        rem  = exp_target - 28'(sum_len);
        elen = (rem > 28'd64) ? 8'd64 : rem[7:0];
        chk("burst_addr", wr_addr, exp_base + 28'(sum_len));
        chk("burst_len", wr_len, elen);
        nb++;
        sum_len  += int'(wr_len);
        last_len  = int'(wr_len);
        repeat (2) @(negedge clk);
        ack_auto = 1'b1;
        @(negedge clk);
        ack_auto = 1'b0;
      end
    end
  end

  task automatic start_frame(input logic [12:0] h, input logic [12:0] v, input logic [27:0] amax);
    @(negedge clk);
    cmos_h_pixel = h; cmos_v_pixel = v; ddr3_addr_max = amax;
    wr_frame_start = 1'b1;
    @(negedge clk);
    wr_frame_start = 1'b0;
  endtask

  task automatic pixels(input int n);
    for (int i = 0; i < n; i++) begin
      wr_pix_vld = 1'b1;
      @(negedge clk);
    end
    wr_pix_vld = 1'b0;
  endtask

  task automatic wait_fc(input int fc);
    for (int k = 0; k < 400 && frame_cnt != 16'(fc); k++) @(negedge clk);
    chk("frame_cnt", frame_cnt, fc);
  endtask

  task automatic wait_req(input string nm);
    for (int k = 0; k < 40 && !wr_req; k++) @(negedge clk);
    chk(nm, wr_req, 1);
  endtask

  task automatic run_frame(input frame_t f);
    if (f.rd_pulse) begin
      @(negedge clk); rd_frame_start = 1'b1;
      @(negedge clk); rd_frame_start = 1'b0;
    end
    nb = 0; sum_len = 0; last_len = 0;
    exp_base = base_of(f.bank); exp_target = f.tgt; resp_en = 1'b1;
    start_frame(f.h, f.v, f.amax);
    pixels(f.npix);
    wait_fc(f.fc);
    chk("nbursts", nb, f.nbursts);
    chk("words", sum_len, f.tgt);
    chk("last_len", last_len, f.last);
    chk("wr_bank", wr_bank, f.wr_after);
    chk("rd_bank", rd_bank, f.rd_after);
    chk("rd_base", rd_base, base_of(f.rd_after));
    resp_en = 1'b0;
  endtask

  task automatic chk_reset_vals();
    chk("rst_wr_req", wr_req, 0);
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_wr_len", wr_len, 0);
    chk("rst_wr_bank", wr_bank, 0);
    chk("rst_rd_bank", rd_bank, 2);
    chk("rst_rd_base", rd_base, 28'h0400000);
    chk("rst_frame_err", frame_err, 0);
    chk("rst_frame_cnt", frame_cnt, 0);
  endtask

  initial begin
    frame_t f;
    rst = 1'b1; ack_man = 1'b0; resp_en = 1'b0;
    cmos_h_pixel = 13'd0; cmos_v_pixel = 13'd0; ddr3_addr_max = 28'd0;
    wr_frame_start = 1'b0; wr_pix_vld = 1'b0; rd_frame_start = 1'b0;
    exp_base = 28'd0; exp_target = 28'd0; nb = 0; sum_len = 0; last_len = 0;

    //        h        v        amax     npix  rd   tgt   bank nb last wr   rd   fc
    tbl[0] = '{13'd5,    13'd5,    28'd1000, 26,   1'b0, 28'd25,   2'd0, 1,  25, 2'd1, 2'd2, 1};
    tbl[1] = '{13'd40,   13'd40,   28'd1000, 1000, 1'b0, 28'd1000, 2'd1, 16, 40, 2'd0, 2'd2, 2};
    tbl[2] = '{13'd8191, 13'd8191, 28'd130,  130,  1'b0, 28'd130,  2'd0, 3,  2,  2'd1, 2'd2, 3};
    tbl[3] = '{13'd10,   13'd10,   28'd80,   100,  1'b0, 28'd80,   2'd1, 2,  16, 2'd0, 2'd2, 4};
    tbl[4] = '{13'd0,    13'd5,    28'd1000, 3,    1'b1, 28'd0,    2'd0, 0,  0,  2'd2, 2'd1, 5};

    repeat (3) @(negedge clk);
    chk_reset_vals();
    rst = 1'b0;

    for (int i = 0; i < 5; i++) run_frame(tbl[i]);

    // Restart while idle on the bus: counters clear, same bank, no rotation.
    nb = 0; sum_len = 0; last_len = 0;
    exp_base = base_of(2'd2); exp_target = 28'd25; resp_en = 1'b1;
    start_frame(13'd5, 13'd5, 28'd1000);
    pixels(10);
    wr_frame_start = 1'b1;
    @(negedge clk);
    wr_frame_start = 1'b0;
    chk("restart_err", frame_err, 1);
    @(negedge clk);
    chk("restart_err_pulse", frame_err, 0);
    pixels(25);
    wait_fc(6);
    chk("restart_nb", nb, 1);
    chk("restart_len", last_len, 25);
    chk("restart_wr_bank", wr_bank, 0);
    resp_en = 1'b0;

    // Restart with a request outstanding: abort until ack, then idle.
    start_frame(13'd40, 13'd40, 28'd1000);
    pixels(100);
    chk("abort_req", wr_req, 1);
    chk("abort_addr", wr_addr, 0);
    chk("abort_len", wr_len, 64);
    wr_frame_start = 1'b1;
    @(negedge clk);
    wr_frame_start = 1'b0;
    chk("abort_err", frame_err, 1);
    chk("abort_req_held", wr_req, 1);
    wr_frame_start = 1'b1; wr_pix_vld = 1'b1;
    @(negedge clk);
    wr_frame_start = 1'b0;
    pixels(4);
    chk("abort_start_ignored", frame_err, 0);
    chk("abort_req_hold2", wr_req, 1);
    ack_man = 1'b1;
    @(negedge clk);
    ack_man = 1'b0;
    chk("abort_req_drop", wr_req, 0);
    pixels(80);
    @(negedge clk);
    chk("idle_no_req", wr_req, 0);
    chk("abort_fc", frame_cnt, 6);
    chk("abort_wr_bank", wr_bank, 0);

    // Reset with a burst outstanding.
    start_frame(13'd40, 13'd40, 28'd1000);
    pixels(70);
    chk("pre_rst_req", wr_req, 1);
    rst = 1'b1;
    @(negedge clk);
    chk_reset_vals();
    rst = 1'b0;

    // Three frames, reader starts in the same cycle as the second completion.
    f = '{13'd5, 13'd5, 28'd1000, 25, 1'b0, 28'd25, 2'd0, 1, 25, 2'd1, 2'd2, 1};
    run_frame(f);
    start_frame(13'd5, 13'd5, 28'd1000);
    pixels(25);
    wait_req("f2_req");
    chk("f2_addr", wr_addr, STRIDE);
    chk("f2_len", wr_len, 25);
    ack_man = 1'b1;
    @(negedge clk);
    ack_man = 1'b0;
    @(negedge clk);
    rd_frame_start = 1'b1;
    @(negedge clk);
    rd_frame_start = 1'b0;
    chk("coinc_fc", frame_cnt, 2);
    chk("coinc_rd_bank", rd_bank, 1);
    chk("coinc_rd_base", rd_base, STRIDE);
    chk("coinc_wr_bank", wr_bank, 2);
    f = '{13'd5, 13'd5, 28'd1000, 25, 1'b0, 28'd25, 2'd2, 1, 25, 2'd0, 2'd1, 3};
    run_frame(f);

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
